// File: rtl/uart_rx_sequencer_if.sv
// rtl/uart_rx_sequencer_if.sv - Signal bundle between baud source/consumer and the RX sequencer.
// Optional parity error output is present when UART_RX_PARITY_EN is defined.
interface uart_rx_if #(
    parameter int SIZE = 8
);
    logic            i_baud_tick;
    logic            i_rx_enable;
    logic            i_rxd;
    logic [SIZE-1:0] o_data_out;
    logic            o_rxrdy;
    logic            o_frame_err;
    logic            o_shift_en;
    logic            o_busy;
`ifdef UART_RX_PARITY_EN
    logic            o_parity_err;

    modport master (output i_baud_tick, i_rx_enable, i_rxd,
                    input  o_data_out, o_rxrdy, o_frame_err, o_shift_en, o_busy, o_parity_err);
    modport slave  (input  i_baud_tick, i_rx_enable, i_rxd,
                    output o_data_out, o_rxrdy, o_frame_err, o_shift_en, o_busy, o_parity_err);
`else
    modport master (output i_baud_tick, i_rx_enable, i_rxd,
                    input  o_data_out, o_rxrdy, o_frame_err, o_shift_en, o_busy);
    modport slave  (input  i_baud_tick, i_rx_enable, i_rxd,
                    output o_data_out, o_rxrdy, o_frame_err, o_shift_en, o_busy);
`endif
endinterface

// File: rtl/uart_rx_sequencer.sv
// rtl/uart_rx_sequencer.sv - Tick-timed UART receive FSM: start qualify, mid-bit sample, stop check.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx_sequencer #(
    parameter int SIZE       = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic   i_clk,
    input  logic   i_rst,
    uart_rx_if.slave bus
);
    localparam int TW = $clog2(OVERSAMPLE) + 1;
    localparam int BW = $clog2(SIZE) + 1;

    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] TICK_FULL = TW'(OVERSAMPLE);
    localparam logic [BW-1:0] BIT_LAST  = BW'(SIZE - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd4;
`endif

    logic [2:0]      r_state;
    logic [TW-1:0]   r_tick;
    logic [BW-1:0]   r_bit;
    logic [SIZE-1:0] r_shift;
    logic [SIZE-1:0] r_data;
    logic            r_sync1;
    logic            r_sync2;
    logic            r_prev;
    logic            r_rxrdy;
    logic            r_frame_err;
    logic            r_shift_en;
    logic [TW-1:0]   w_tick_next;
    logic            w_enable;
`ifdef UART_RX_PARITY_EN
    logic            r_par_pend;
    logic            r_parity_err;
    assign bus.o_parity_err = r_parity_err;
`endif

    assign w_tick_next     = r_tick + 1'b1;
    assign w_enable        = bus.i_rx_enable;
    assign bus.o_data_out  = r_data;
    assign bus.o_rxrdy     = r_rxrdy;
    assign bus.o_frame_err = r_frame_err;
    assign bus.o_shift_en  = r_shift_en;
    assign bus.o_busy      = (r_state != S_IDLE);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_tick      <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_prev      <= 1'b1;
            r_rxrdy     <= 1'b0;
            r_frame_err <= 1'b0;
            r_shift_en  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_pend   <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_sync1    <= bus.i_rxd;
            r_sync2    <= r_sync1;
            r_prev     <= r_sync2;
            r_rxrdy    <= 1'b0;
            r_shift_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_enable && r_prev && !r_sync2) begin
                        r_state <= S_START;
                        r_tick  <= '0;
                    end
                end
                S_START: begin
                    if (!w_enable) begin
                        r_state <= S_IDLE;
                    end else if (bus.i_baud_tick) begin
                        if (w_tick_next == TICK_HALF) begin
                            // A high line at mid start bit means the edge was noise.
                            if (!r_sync2) begin
                                r_state <= S_DATA;
                                r_tick  <= '0;
                                r_bit   <= '0;
                                r_shift <= '0;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_tick <= w_tick_next;
                        end
                    end
                end
                S_DATA: begin
                    if (!w_enable) begin
                        r_state <= S_IDLE;
                    end else if (bus.i_baud_tick) begin
                        if (w_tick_next == TICK_FULL) begin
                            r_tick     <= '0;
                            r_shift    <= {r_sync2, r_shift[SIZE-1:1]};
                            r_shift_en <= 1'b1;
                            if (r_bit == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                                r_state <= S_PARITY;
`else
                                r_state <= S_STOP;
`endif
                            end else begin
                                r_bit <= r_bit + 1'b1;
                            end
                        end else begin
                            r_tick <= w_tick_next;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (!w_enable) begin
                        r_state <= S_IDLE;
                    end else if (bus.i_baud_tick) begin
                        if (w_tick_next == TICK_FULL) begin
                            r_tick     <= '0;
                            r_par_pend <= (^r_shift) ^ r_sync2;
                            r_state    <= S_STOP;
                        end else begin
                            r_tick <= w_tick_next;
                        end
                    end
                end
`endif
                S_STOP: begin
                    if (!w_enable) begin
                        r_state <= S_IDLE;
                    end else if (bus.i_baud_tick) begin
                        if (w_tick_next == TICK_FULL) begin
                            r_tick      <= '0;
                            r_data      <= r_shift;
                            r_frame_err <= ~r_sync2;
                            r_rxrdy     <= 1'b1;
                            r_state     <= S_IDLE;
`ifdef UART_RX_PARITY_EN
                            r_parity_err <= r_par_pend;
`endif
                        end else begin
                            r_tick <= w_tick_next;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/uart_rx_sequencer.md
Name: uart_rx_sequencer

Overview:
- Sequences reception of one asynchronous serial frame on the RX side: start-bit qualification, mid-bit sampling, data shifting, stop-bit check.
- Sits between the baud-rate generator, which supplies the oversample tick, and the RX consumer, which reads DATA_OUT on RXRDY.
- Replaces the free-running bit counting of the current RX control path with an explicit, tick-timed FSM that has abort and error reporting.

Parameters:
- SIZE, 8: data bits per frame, sent LSB first; legal range 5..9.
- OVERSAMPLE, 16: BAUD_TICK pulses per bit period; even, >= 4.

Ports:
- CLK  input  1  system clock; all state updates on posedge.
- RST  input  1  asynchronous, active-high reset.
- BAUD_TICK  input  1  one-CLK pulse at OVERSAMPLE x baud rate.
- RX_ENABLE  input  1  receiver enable; low aborts or blocks reception.
- RXD  input  1  raw serial line, idle high, asynchronous to CLK.
- DATA_OUT  output  SIZE  last received data word.
- RXRDY  output  1  one-CLK pulse when a frame completes.
- FRAME_ERR  output  1  stop bit of the last completed frame sampled as 0.
- SHIFT_EN  output  1  one-CLK pulse on each data-bit sample.
- BUSY  output  1  high in any state other than IDLE.

Behaviour:
- Reset:
  - DATA_OUT=0, RXRDY=0, FRAME_ERR=0, SHIFT_EN=0, BUSY=0.
  - FSM goes to IDLE; tick and bit counters clear.
  - Both synchronizer flops and the previous-sample register reset to 1.
- RXD passes through a 2-flop synchronizer, giving 2 CLK latency. The FSM uses only the synchronized value rxs and its one-cycle-delayed copy.
- IDLE:
  - Leaves on a falling edge (prev=1, rxs=0) while RX_ENABLE=1 and goes to START.
  - Clears the tick counter on entry to START.
- START:
  - Counts BAUD_TICKs.
  - On tick number OVERSAMPLE/2, which is mid start bit, samples rxs.
  - rxs=0: go to DATA, clear the tick counter, set the bit index to 0.
  - rxs=1: the start was a glitch; go to IDLE with no outputs.
- DATA:
  - Counts BAUD_TICKs; every OVERSAMPLE-th tick samples rxs at mid-bit.
  - Each sample shifts into the internal shift register from the MSB side, so the LSB arrives first, and pulses SHIFT_EN for exactly 1 CLK.
  - After the sample with bit index SIZE-1, go to STOP (or PARITY with the macro enabled) and clear the tick counter.
- STOP:
  - On the OVERSAMPLE-th tick, samples rxs.
  - DATA_OUT <= shift register; FRAME_ERR <= ~rxs; RXRDY pulses for 1 CLK; go to IDLE.
- Output timing and hold:
  - DATA_OUT and FRAME_ERR update in the same cycle that RXRDY is high.
  - Both hold their values until the next RXRDY.
- After a framing error (line held low), IDLE re-arms only once rxs has returned to 1; the falling-edge rule enforces this.
- Abort: RX_ENABLE=0 in START, DATA or STOP returns the FSM to IDLE on the next CLK.
  - No RXRDY pulse.
  - DATA_OUT and FRAME_ERR are unchanged.
  - The partially shifted data is discarded.
- Ticks:
  - BAUD_TICK is ignored in IDLE.
  - Counters advance only on CLK edges where BAUD_TICK=1.
  - Tick counter width is clog2(OVERSAMPLE)+1; bit index width is clog2(SIZE)+1. Neither counter wraps within a frame.
- Back-to-back frames: a start edge arriving in the first IDLE cycle after STOP is accepted, so there is no dead cycle.
- RST asserted mid-frame: immediate return to the reset state, with no RXRDY pulse.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - Adds a PARITY state between DATA and STOP, sampled on the OVERSAMPLE-th tick.
  - Adds output PARITY_ERR (1 bit, resets to 0). It is set to XOR(data bits, parity bit) for even parity, is updated together with RXRDY, and holds until the next RXRDY.
- When undefined: no PARITY state, no PARITY_ERR port, and the frame is start + SIZE data bits + stop.

Test Plan:
- Frame 0xA5 with valid stop, OVERSAMPLE=16 -> one RXRDY pulse, DATA_OUT=0xA5, FRAME_ERR=0, exactly 8 SHIFT_EN pulses, BUSY high from start detect to RXRDY.
- RXD low for 4 ticks, then high -> BUSY pulses briefly, then the FSM returns to IDLE; no RXRDY, no SHIFT_EN, DATA_OUT unchanged.
- Frame 0x3C with stop bit 0, line then returned high -> RXRDY pulse, DATA_OUT=0x3C, FRAME_ERR=1; next valid frame 0x11 -> FRAME_ERR=0.
- RX_ENABLE dropped after 3 data bits of 0xFF -> BUSY=0 next CLK, no RXRDY, DATA_OUT keeps its prior value. Then RST pulsed mid-frame -> all outputs 0.
- Back-to-back 0x00 then 0xFF with no idle gap after the stop bit -> two RXRDY pulses, DATA_OUT=0x00 then 0xFF, FRAME_ERR=0 for both.
- With UART_RX_PARITY_EN defined: 0x07 with parity bit 0 -> PARITY_ERR=1; 0x07 with parity bit 1 -> PARITY_ERR=0; DATA_OUT=0x07 in both cases.
